sel_encode_sb: RTL and testbench
================================

// Module: sel_encode_sb
// PURPOSE
//  Parametrised register select/encode stage for the datapath control unit. Holds its own IR copy.
//  Decodes ra/rb/rc into one-hot register-file in/out enables, with an optional registered output stage.
//  Sign- or zero-extends the C constant to DATA_W.
//  Keeps a pending-write scoreboard that flags read-after-write hazards to the control FSM.
// PARAMETERS
//  NREG     16   number of GP registers (power of 2, 4..32); IDX_W = $clog2(NREG)
//  DATA_W   32   IR / datapath width
//  OP_W     5    opcode width; opcode = IR[DATA_W-1 -: OP_W]
//  RA_LSB   23   LSB of ra field (IDX_W bits)
//  RB_LSB   19   LSB of rb field
//  RC_LSB   15   LSB of rc field
//  C_W      19   constant field width, IR[C_W-1:0]
//  C_SEXT   1    1: sign-extend C from bit C_W-1; 0: zero-extend
//  OUT_REG  1    1: regin/regout registered (1-cycle latency); 0: combinational
// PORTS
//  clk       in   1       system clock, rising edge
//  clr_n     in   1       asynchronous active-low reset
//  ir_in     in   DATA_W  instruction from bus
//  ir_load   in   1       capture ir_in into internal IR
//  Gra/Grb/Grc in 1       select ra / rb / rc field
//  Rin       in   1       write-enable request
//  Rout      in   1       read-enable request
//  BAout     in   1       base-address read (R0 reads as zero)
//  issue     in   1       mark IR.ra as pending write
//  wb_valid  in   1       write-back complete strobe
//  wb_idx    in   IDX_W   register index being written back
//  opcode    out  OP_W    IR opcode field
//  c_ext     out  DATA_W  extended constant
//  regin     out  NREG    one-hot register load enables
//  regout    out  NREG    one-hot register drive enables
//  ba_zero   out  1       BAout selected R0: bus must drive 0
//  sel_err   out  1       more than one of Gra/Grb/Grc asserted
//  busy      out  NREG    scoreboard pending-write vector
//  hazard    out  1       IR.rb or IR.rc is busy
// BEHAVIOUR
//  Reset: IR, ir_valid, busy, and the output registers all clear to 0.
//   Every output reads 0 while clr_n is low; async assert, sync release.
//  IR: captured on the clk edge when ir_load=1. opcode and c_ext are combinational from IR.
//  Selection priority is Gra > Grb > Grc; idx = the selected field.
//   No select: no enable bits asserted.
//   sel_err = popcount(Gra,Grb,Grc) > 1. It is combinational and OUT_REG-independent.
//  regin[idx]  = Rin.
//  regout[idx] = Rout | (BAout & idx!=0).
//  ba_zero = BAout & idx==0 & ~Rout. ba_zero has the same latency as regout.
//  OUT_REG=1: regin/regout/ba_zero update on the edge after the inputs; latency exactly 1 cycle.
//   When ir_load and a select occur in the same cycle, decode uses the OLD IR.
//  OUT_REG=0: regin/regout/ba_zero are combinational from the current IR and controls.
//  At most one bit set in regin and one in regout, always.
//  c_ext = C_SEXT & IR[C_W-1] ? {ones, IR[C_W-1:0]} : {zeros, IR[C_W-1:0]}.
//  Scoreboard, per edge:
//   issue=1 sets busy[IR.ra] (IR sampled before any same-cycle ir_load).
//   wb_valid=1 clears busy[wb_idx].
//   issue and wb_valid on the same index in the same cycle: set wins (new writer).
//   wb_valid to a non-busy register is a no-op.
//   busy[0] is tracked like any other register.
//  hazard = ir_valid & (busy[IR.rb] | busy[IR.rc]). It is combinational from registered state.
//   ir_valid is set on the first ir_load and cleared only by reset.
//  Reset mid-operation discards all pending busy bits; no write-back is remembered.
// TESTING
//  1. Load IR with ra=5, rb=2; Gra=1, Rin=1 -> regin=16'h0020 the next cycle (OUT_REG=1); regout=0.
//  2. IR.rb=0; Grb=1, BAout=1 -> regout=0, ba_zero=1. Same with rb=3 -> regout=16'h0008, ba_zero=0.
//  3. IR[18:0]=19'h40000, C_SEXT=1 -> c_ext=32'hFFFC0000. C_SEXT=0 -> 32'h00040000.
//  4. issue with ra=7, then load IR with rb=7 -> hazard=1; wb_valid with wb_idx=7 -> busy[7]=0, hazard=0 next cycle.
//  5. issue with ra=4 and wb_valid wb_idx=4 in the same cycle -> busy[4]=1. Gra=Grc=1 -> sel_err=1, only ra decoded.
//  6. Pull clr_n low with busy=16'h00F0 and regout active -> all outputs 0 immediately; stay 0 after release until new stimulus.

Source files
------------

// File: rtl/sel_encode_sb.sv
// rtl/sel_encode_sb.sv - register select/encode stage with constant extension and pending-write scoreboard
// Decodes ra/rb/rc from a private IR copy into one-hot register-file enables and flags RAW hazards.
module sel_encode_sb #(
  parameter int NREG    = 16,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 5,
  parameter int RA_LSB  = 23,
  parameter int RB_LSB  = 19,
  parameter int RC_LSB  = 15,
  parameter int C_W     = 19,
  parameter int C_SEXT  = 1,
  parameter int OUT_REG = 1,
  localparam int IDX_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] ir_in,
  input  logic              ir_load,
  input  logic              Gra,
  input  logic              Grb,
  input  logic              Grc,
  input  logic              Rin,
  input  logic              Rout,
  input  logic              BAout,
  input  logic              issue,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_idx,
  output logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] c_ext,
  output logic [NREG-1:0]   regin,
  output logic [NREG-1:0]   regout,
  output logic              ba_zero,
  output logic              sel_err,
  output logic [NREG-1:0]   busy,
  output logic              hazard
);

  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_nxt;
  logic [IDX_W-1:0]  ra;
  logic [IDX_W-1:0]  rb;
  logic [IDX_W-1:0]  rc;
  logic [IDX_W-1:0]  idx;
  logic              any_sel;
  logic              c_fill;
  logic [NREG-1:0]   regin_c;
  logic [NREG-1:0]   regout_c;
  logic              ba_zero_c;

  assign ra = ir[RA_LSB +: IDX_W];
  assign rb = ir[RB_LSB +: IDX_W];
  assign rc = ir[RC_LSB +: IDX_W];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ir       <= '0;
      ir_valid <= 1'b0;
      busy_q   <= '0;
    end else begin
      if (ir_load) begin
        ir       <= ir_in;
        ir_valid <= 1'b1;
      end
      busy_q <= busy_nxt;
    end
  end

  // Set is applied after clear so a same-cycle issue to the written-back index keeps the new writer.
  always_comb begin
    busy_nxt = busy_q;
    if (wb_valid) busy_nxt[wb_idx] = 1'b0;
    if (issue)    busy_nxt[ra]     = 1'b1;
  end

  assign any_sel = Gra | Grb | Grc;
  assign idx     = Gra ? ra : (Grb ? rb : rc);

  always_comb begin
    regin_c  = '0;
    regout_c = '0;
    for (int i = 0; i < NREG; i++) begin
      regin_c[i]  = any_sel & Rin & (idx == IDX_W'(i));
      regout_c[i] = any_sel & (Rout | (BAout & (idx != '0))) & (idx == IDX_W'(i));
    end
  end

  assign ba_zero_c = any_sel & BAout & (idx == '0) & ~Rout;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [NREG-1:0] regin_q;
      logic [NREG-1:0] regout_q;
      logic            ba_zero_q;

      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
          regin_q   <= '0;
          regout_q  <= '0;
          ba_zero_q <= 1'b0;
        end else begin
          regin_q   <= regin_c;
          regout_q  <= regout_c;
          ba_zero_q <= ba_zero_c;
        end
      end

      assign regin   = regin_q;
      assign regout  = regout_q;
      assign ba_zero = ba_zero_q;
    end else begin : g_out_comb
      // Gated so the whole block reads zero while held in reset.
      assign regin   = clr_n ? regin_c  : '0;
      assign regout  = clr_n ? regout_c : '0;
      assign ba_zero = clr_n & ba_zero_c;
    end
  endgenerate

  assign opcode  = ir[DATA_W-1 -: OP_W];
  assign c_fill  = (C_SEXT != 0) & ir[C_W-1];
  assign c_ext   = {{(DATA_W-C_W){c_fill}}, ir[C_W-1:0]};
  assign sel_err = clr_n & ((Gra & Grb) | (Gra & Grc) | (Grb & Grc));
  assign busy    = busy_q;
  assign hazard  = ir_valid & (busy_q[rb] | busy_q[rc]);

endmodule

// File: tb/tb_sel_encode_sb.sv
// tb/tb_sel_encode_sb.sv - randomized self-checking bench for sel_encode_sb
// Two instances share stimulus: registered/sign-extend and combinational/zero-extend.
module tb_sel_encode_sb;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] ir_in;
  logic        ir_load, Gra, Grb, Grc, Rin, Rout, BAout, issue, wb_valid;
  logic [3:0]  wb_idx;

  logic [4:0]  opcode,  opcode0;
  logic [31:0] c_ext,   c_ext0;
  logic [15:0] regin,   regin0, regout, regout0, busy, busy0;
  logic        ba_zero, ba_zero0, sel_err, sel_err0, hazard, hazard0;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference state: IR, valid flag, pending writers, and what the registered stage must show.
  logic [31:0] mir;
  bit          mvalid;
  logic [15:0] mbusy;
  logic [15:0] m_ri, m_ro;
  logic        m_bz;

  sel_encode_sb dut (
    .clk(clk), .clr_n(clr_n), .ir_in(ir_in), .ir_load(ir_load),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .issue(issue), .wb_valid(wb_valid), .wb_idx(wb_idx),
    .opcode(opcode), .c_ext(c_ext), .regin(regin), .regout(regout),
    .ba_zero(ba_zero), .sel_err(sel_err), .busy(busy), .hazard(hazard)
  );

  sel_encode_sb #(.C_SEXT(0), .OUT_REG(0)) dut0 (
    .clk(clk), .clr_n(clr_n), .ir_in(ir_in), .ir_load(ir_load),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .issue(issue), .wb_valid(wb_valid), .wb_idx(wb_idx),
    .opcode(opcode0), .c_ext(c_ext0), .regin(regin0), .regout(regout0),
    .ba_zero(ba_zero0), .sel_err(sel_err0), .busy(busy0), .hazard(hazard0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int low);
    logic [31:0] v;
    v = (32'(op) << 27) | (32'(ra) << 23) | (32'(rb) << 19) | (32'(low) & 32'h7FFFF);
    return v;
  endfunction

  function automatic void dec(input logic [31:0] ir, input logic ga, input logic gb, input logic gc,
                              input logic rin, input logic rout, input logic ba,
                              output logic [15:0] ri, output logic [15:0] ro, output logic bz);
    int field;
    ri = '0;
    ro = '0;
    bz = 1'b0;
    field = ga ? int'(ir[26:23]) : (gb ? int'(ir[22:19]) : int'(ir[18:15]));
    if (ga || gb || gc) begin
      if (rin) ri = 16'h1 << field;
      if (rout || (ba && field != 0)) ro = 16'h1 << field;
      bz = ba && field == 0 && !rout;
    end
  endfunction

  function automatic logic [31:0] cx(input logic [31:0] ir, input bit sext);
    logic [31:0] c;
    c = 32'(ir[18:0]);
    if (sext && ir[18]) c = c - 32'h0008_0000;
    return c;
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mir = '0; mvalid = 0; mbusy = '0; m_ri = '0; m_ro = '0; m_bz = 1'b0;
    end else begin
      dec(mir, Gra, Grb, Grc, Rin, Rout, BAout, m_ri, m_ro, m_bz);
      if (wb_valid) mbusy = mbusy & ~(16'h1 << wb_idx);
      if (issue) mbusy = mbusy | (16'h1 << mir[26:23]);
      if (ir_load) begin
        mir = ir_in;
        mvalid = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] ri0, ro0;
    logic bz0, se, hz;
    if (chk_en) begin
      dec(mir, Gra, Grb, Grc, Rin, Rout, BAout, ri0, ro0, bz0);
      if (!clr_n) begin ri0 = '0; ro0 = '0; bz0 = 1'b0; end
      se = clr_n && ((32'(Gra) + 32'(Grb) + 32'(Grc)) > 1);
      hz = mvalid && (mbusy[mir[22:19]] || mbusy[mir[18:15]]);
      chk("opcode",   32'(opcode),   32'(mir[31:27]));
      chk("c_ext",    c_ext,         cx(mir, 1));
      chk("regin",    32'(regin),    32'(m_ri));
      chk("regout",   32'(regout),   32'(m_ro));
      chk("ba_zero",  32'(ba_zero),  32'(m_bz));
      chk("sel_err",  32'(sel_err),  32'(se));
      chk("busy",     32'(busy),     32'(mbusy));
      chk("hazard",   32'(hazard),   32'(hz));
      chk("opcode0",  32'(opcode0),  32'(mir[31:27]));
      chk("c_ext0",   c_ext0,        cx(mir, 0));
      chk("regin0",   32'(regin0),   32'(ri0));
      chk("regout0",  32'(regout0),  32'(ro0));
      chk("ba_zero0", 32'(ba_zero0), 32'(bz0));
      chk("sel_err0", 32'(sel_err0), 32'(se));
      chk("busy0",    32'(busy0),    32'(mbusy));
      chk("hazard0",  32'(hazard0),  32'(hz));
    end
  end

  task automatic idle();
    ir_load = 0; Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
    issue = 0; wb_valid = 0; wb_idx = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_regin"},  32'(regin),  0);
    chk({tag, "_regout"}, 32'(regout), 0);
    chk({tag, "_regout0"}, 32'(regout0), 0);
    chk({tag, "_bz"},     32'(ba_zero), 0);
    chk({tag, "_busy"},   32'(busy),   0);
    chk({tag, "_hazard"}, 32'(hazard), 0);
    chk({tag, "_opcode"}, 32'(opcode), 0);
    chk({tag, "_c_ext"},  c_ext,       0);
    chk({tag, "_selerr"}, 32'(sel_err), 0);
  endtask

  initial begin
    clr_n = 1'b0;
    ir_in = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    all_zero("rst");
    clr_n = 1'b1;
    chk_en = 1'b1;

    // Decode ra into regin, one cycle late on the registered instance.
    next(); ir_in = mk(3, 5, 2, 19'h08000); ir_load = 1;
    next(); Gra = 1; Rin = 1;
    @(negedge clk); chk("t1_regin0", 32'(regin0), 32'h0020); chk("t1_regin_early", 32'(regin), 0);
    next();
    @(negedge clk); chk("t1_regin", 32'(regin), 32'h0020); chk("t1_regout", 32'(regout), 0);
    chk("t1_opcode", 32'(opcode), 3);

    // Base-address read of R0 versus R3.
    next(); ir_in = mk(0, 1, 0, 0); ir_load = 1;
    next(); Grb = 1; BAout = 1;
    next();
    @(negedge clk); chk("t2_regout_r0", 32'(regout), 0); chk("t2_bz_r0", 32'(ba_zero), 1);
    next(); ir_in = mk(0, 1, 3, 0); ir_load = 1;
    next(); Grb = 1; BAout = 1;
    next();
    @(negedge clk); chk("t2_regout_r3", 32'(regout), 32'h0008); chk("t2_bz_r3", 32'(ba_zero), 0);

    // Constant extension.
    next(); ir_in = mk(0, 0, 0, 19'h40000); ir_load = 1;
    next();
    @(negedge clk); chk("t3_sext", c_ext, 32'hFFFC_0000); chk("t3_zext", c_ext0, 32'h0004_0000);

    // Issue to r7 while loading a reader of r7, then write back.
    next(); ir_in = mk(0, 7, 1, 0); ir_load = 1;
    next(); issue = 1; ir_in = mk(0, 2, 7, 0); ir_load = 1;
    next(); wb_valid = 1; wb_idx = 4'd7;
    @(negedge clk); chk("t4_busy7", 32'(busy[7]), 1); chk("t4_hazard", 32'(hazard), 1);
    next();
    @(negedge clk); chk("t4_busy7_clr", 32'(busy[7]), 0); chk("t4_hazard_clr", 32'(hazard), 0);

    // Same-cycle set and clear on r4, then a multi-select.
    next(); ir_in = mk(0, 4, 1, 19'h48000); ir_load = 1;
    next(); issue = 1; wb_valid = 1; wb_idx = 4'd4;
    next(); Gra = 1; Grc = 1; Rin = 1;
    @(negedge clk); chk("t5_busy", 32'(busy), 32'h0010); chk("t5_sel_err", 32'(sel_err), 1);
    chk("t5_regin0", 32'(regin0), 32'h0010);
    next();
    @(negedge clk); chk("t5_regin", 32'(regin), 32'h0010);

    // Fill r4..r7, drive r7, then reset mid-operation.
    next(); ir_in = mk(0, 5, 1, 0); ir_load = 1;
    next(); issue = 1; ir_in = mk(0, 6, 1, 0); ir_load = 1;
    next(); issue = 1; ir_in = mk(0, 7, 1, 0); ir_load = 1;
    next(); issue = 1;
    next(); Gra = 1; Rout = 1;
    next();
    @(negedge clk); chk("t6_busy", 32'(busy), 32'h00F0); chk("t6_regout", 32'(regout), 32'h0080);
    #2 clr_n = 1'b0;
    #1 all_zero("t6_inrst");
    next();
    next(); clr_n = 1'b1;
    next();
    @(negedge clk); all_zero("t6_post");

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      next();
      clr_n    = ($urandom_range(0, 199) != 0);
      ir_in    = $urandom;
      ir_load  = ($urandom_range(0, 3) == 0);
      Gra      = ($urandom_range(0, 2) == 0);
      Grb      = ($urandom_range(0, 2) == 0);
      Grc      = ($urandom_range(0, 2) == 0);
      Rin      = 1'($urandom);
      Rout     = 1'($urandom);
      BAout    = ($urandom_range(0, 3) == 0);
      issue    = ($urandom_range(0, 3) == 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_idx   = 4'($urandom);
    end
    next();
    clr_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
